// File: rtl/rv_core_pkg.sv
// Core-wide integer register-file constants shared by the writeback and memory-port logic.
package rv_core_pkg;
  localparam int XLEN  = 32;
  localparam int AW    = 5;
  localparam int NREGS = 32;
  localparam logic [AW-1:0] REG_X0 = '0;
endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: ptr_i names the highest-priority requester.
// Grant is one-hot or zero; idx_o is the winner index (0 when nothing is granted).
module rr_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int PW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [PW-1:0]      ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [PW-1:0]      idx_o
);

  logic          found;
  logic [PW:0]   sum;
  logic [PW-1:0] cand;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    sum   = '0;
    cand  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      // ptr + k never exceeds 2*NUM_REQ-2, so a single wrap is enough
      sum = {1'b0, ptr_i} + (PW+1)'(k);
      if (sum >= (PW+1)'(NUM_REQ)) sum = sum - (PW+1)'(NUM_REQ);
      cand = sum[PW-1:0];
      if (!found && req_i[cand]) begin
        found        = 1'b1;
        gnt_o[cand]  = 1'b1;
        idx_o        = cand;
      end
    end
  end

endmodule

// File: rtl/regfile_wb_sched.sv
// Register-file writeback scheduler: round-robin write-port arbitration, one registered write
// stage, pending-write scoreboard with RAW/WAW issue stall. Bypass outputs with REGFILE_WB_SCHED_BYPASS_EN.
module regfile_wb_sched #(
  parameter int NUM_REQ = 3,
  parameter int XLEN    = rv_core_pkg::XLEN,
  parameter int AW      = rv_core_pkg::AW
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*AW-1:0]         req_rd,
  input  logic [NUM_REQ*XLEN-1:0]       req_data,
  input  logic                          iss_valid,
  input  logic [AW-1:0]                 iss_rd,
  input  logic [AW-1:0]                 iss_rs1,
  input  logic [AW-1:0]                 iss_rs2,
  output logic                          iss_stall,
  output logic                          rf_we,
  output logic [AW-1:0]                 rf_waddr,
  output logic [XLEN-1:0]               rf_wdata,
  output logic [rv_core_pkg::NREGS-1:0] pending
`ifdef REGFILE_WB_SCHED_BYPASS_EN
  ,
  output logic                          fwd_rs1_hit,
  output logic                          fwd_rs2_hit,
  output logic [XLEN-1:0]               fwd_data
`endif
);
  import rv_core_pkg::*;

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PW-1:0]      ptr_q, ptr_d;
  logic [NUM_REQ-1:0] gnt;
  logic [PW-1:0]      win_idx;
  logic [AW-1:0]      win_rd;
  logic [XLEN-1:0]    win_data;
  logic               any_gnt;

  logic               rf_we_q, rf_we_d;
  logic [AW-1:0]      rf_waddr_q, rf_waddr_d;
  logic [XLEN-1:0]    rf_wdata_q, rf_wdata_d;
  logic [NREGS-1:0]   pending_q, pending_d;
  logic [NREGS-1:0]   set_vec, clr_vec;
  logic               rs1_hz, rs2_hz, rd_hz;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .PW(PW)) u_arb (
    .req_i (req_valid),
    .ptr_i (ptr_q),
    .gnt_o (gnt),
    .idx_o (win_idx)
  );

  assign req_ready = gnt;
  assign any_gnt   = |gnt;

  // Grant is one-hot, so OR-ing the masked fields selects the winner
  always_comb begin
    win_rd   = '0;
    win_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        win_rd   = win_rd | req_rd[i*AW +: AW];
        win_data = win_data | req_data[i*XLEN +: XLEN];
      end
    end
  end

  always_comb begin
    ptr_d      = ptr_q;
    rf_we_d    = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    if (any_gnt) begin
      ptr_d      = (win_idx == PW'(NUM_REQ-1)) ? '0 : win_idx + PW'(1);
      rf_we_d    = (win_rd != REG_X0);
      rf_waddr_d = win_rd;
      rf_wdata_d = win_data;
    end
  end

`ifdef REGFILE_WB_SCHED_BYPASS_EN
  assign fwd_rs1_hit = rf_we_q && (rf_waddr_q == iss_rs1) && (iss_rs1 != REG_X0);
  assign fwd_rs2_hit = rf_we_q && (rf_waddr_q == iss_rs2) && (iss_rs2 != REG_X0);
  assign fwd_data    = rf_wdata_q;
  assign rs1_hz      = (iss_rs1 != REG_X0) && pending_q[iss_rs1] && !fwd_rs1_hit;
  assign rs2_hz      = (iss_rs2 != REG_X0) && pending_q[iss_rs2] && !fwd_rs2_hit;
`else
  assign rs1_hz      = (iss_rs1 != REG_X0) && pending_q[iss_rs1];
  assign rs2_hz      = (iss_rs2 != REG_X0) && pending_q[iss_rs2];
`endif
  assign rd_hz     = (iss_rd != REG_X0) && pending_q[iss_rd];
  assign iss_stall = iss_valid && (rs1_hz || rs2_hz || rd_hz);

  // Set is applied after clear: a same-cycle new writer stays outstanding
  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    if (iss_valid && !iss_stall && (iss_rd != REG_X0)) set_vec[iss_rd] = 1'b1;
    if (rf_we_q) clr_vec[rf_waddr_q] = 1'b1;
    pending_d    = (pending_q & ~clr_vec) | set_vec;
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q      <= '0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      pending_q  <= '0;
    end else begin
      ptr_q      <= ptr_d;
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
      pending_q  <= pending_d;
    end
  end

  assign rf_we    = rf_we_q;
  assign rf_waddr = rf_waddr_q;
  assign rf_wdata = rf_wdata_q;
  assign pending  = pending_q;

endmodule
